tic_timer_sched: RTL and testbench
==================================

// Module: tic_timer_sched
// PURPOSE
//   Multi-channel timer scheduler driven by the shared base tick (m_counter tic, 1 pulse per
//   MAXCOUNT+1 clocks). Each channel counts a programmed number of tics, periodic or one-shot,
//   and flags expiry. Expiries from all channels are queued round-robin onto one
//   valid/ready event port. The scheduler lets several consumers share a single tick source.
// PARAMETERS
//   NCH   4    number of timer channels (2..16)
//   CW    17   channel period/count width in tics (17 bits holds 99_999)
//   IDW   $clog2(NCH)  localparam, width of channel index
// PORTS
//   clk         in   1     system clock, all logic on rising edge
//   rst         in   1     synchronous, active-high reset
//   tic_in      in   1     base tick, single-cycle pulse from m_counter
//   cfg_we      in   1     config write strobe, one channel per cycle
//   cfg_ch      in   IDW   channel index for cfg_we
//   cfg_en      in   1     1 = arm channel, 0 = disarm channel
//   cfg_oneshot in   1     1 = one-shot, 0 = periodic (sampled on cfg_we)
//   cfg_period  in   CW    period in tics (sampled on cfg_we)
//   cfg_err     out  1     1-cycle pulse: rejected config (cfg_en=1 with cfg_period=0)
//   evt_valid   out  1     expiry event available
//   evt_ready   in   1     consumer accepts event when evt_valid && evt_ready
//   evt_id      out  IDW   channel that expired; stable while evt_valid=1
//   armed       out  NCH   per-channel ARMED status
//   overrun     out  NCH   sticky: channel expired while its previous expiry still pending
// BEHAVIOUR
//   Reset: all channels IDLE, cnt=0, period=0, pending=0, overrun=0; evt_valid=0, evt_id=0,
//     cfg_err=0, rr pointer=NCH-1 (channel 0 has first priority). Reset mid-operation discards
//     everything, including an un-accepted event.
//   Channel FSM (per channel): IDLE, ARMED.
//     cfg_we, cfg_en=1, period!=0: -> ARMED, cnt<=cfg_period, store mode/period, overrun<=0.
//     cfg_we, cfg_en=1, period==0: -> IDLE, cnt<=0, cfg_err pulses next cycle; pending kept.
//     cfg_we, cfg_en=0: -> IDLE, cnt<=0, pending<=0, overrun<=0.
//     ARMED && tic_in: cnt!=1 -> cnt-1; cnt==1 -> expire: set pending; periodic reloads
//       cnt<=period (stays ARMED), one-shot -> IDLE, cnt<=0.
//     cfg_we to a channel wins over tic_in on that channel in the same cycle (tic ignored there);
//       other channels still see the tic.
//     IDLE channels ignore tic_in. Period P => expiry on the P-th tic after arming.
//   Pending/overrun: expire while pending=1 and not being granted that cycle -> overrun<=1,
//     pending stays 1 (events merge). Grant-clear and expire on same channel same cycle ->
//     pending stays 1, no overrun.
//   Event slot (registered): loads when evt_valid=0 or (evt_valid && evt_ready).
//     Selects first pending channel searching rr+1, rr+2, ... mod NCH; clears its pending,
//     evt_id<=ch, evt_valid<=1, rr<=ch. No pending -> evt_valid<=0 (if slot freed).
//     Back-to-back: with evt_ready=1 and ≥2 pending, one event per cycle, no bubble.
//   Latency: tic at edge N expiring a channel -> pending at N -> evt_valid=1 after edge N+1
//     (if slot free). evt_valid/evt_id never change while evt_valid && !evt_ready.
//   armed = (state==ARMED); overrun is registered, cleared only by cfg_we to that channel or rst.
// TESTING
//   1. rst 2 cycles -> evt_valid=0, evt_id=0, armed=0, overrun=0, cfg_err=0.
//   2. Arm ch1 periodic period=3, evt_ready=1, tic every 5 clks -> evt_id=1 after tics 3,6,9;
//      evt_valid high exactly 1 cycle, one cycle after each 3rd tic.
//   3. Arm ch0..3 one-shot period=2, evt_ready=0 -> after tic 2 evt_id=0 held; then ready=1 ->
//      ids 0,1,2,3 on 4 consecutive cycles, then evt_valid=0; armed=0000.
//   4. Arm ch2 periodic period=1, evt_ready=0, 3 tics -> overrun[2]=1, single event id=2;
//      cfg_we ch2 en=1 period=1 -> overrun[2]=0.
//   5. cfg_we ch0 en=1 period=0 -> cfg_err pulse 1 cycle, armed[0]=0; cfg_we ch1 same cycle as
//      tic_in with cnt=1 -> no event from ch1, cnt reloads to new period.
//   6. Assert rst while evt_valid=1 and ch3 ARMED -> next cycle evt_valid=0, armed=0, no event
//      after further tics.

Source files
------------

// File: rtl/tic_timer_sched.sv
// Purpose: NCH tic-driven countdown timers (periodic/one-shot), expiries merged onto one event port.
// Latency: tic edge that expires a channel sets pending; evt_valid rises one clock later if the slot is free.
// Backpressure: event slot holds evt_valid/evt_id while !evt_ready; repeated expiries merge and set overrun.
module tic_timer_sched #(
  parameter int NCH = 4,
  parameter int CW  = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tic_in,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic                     cfg_en,
  input  logic                     cfg_oneshot,
  input  logic [CW-1:0]            cfg_period,
  output logic                     cfg_err,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(NCH)-1:0]   evt_id,
  output logic [NCH-1:0]           armed,
  output logic [NCH-1:0]           overrun
);

  localparam int IDW = $clog2(NCH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } ch_state_e;

  ch_state_e      state_q  [NCH];
  ch_state_e      state_d  [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [NCH-1:0] oneshot_q, oneshot_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  logic           cfg_err_q, cfg_err_d;
  logic           evt_valid_q, evt_valid_d;
  logic [IDW-1:0] evt_id_q, evt_id_d;
  logic [IDW-1:0] rr_q, rr_d;

  logic           slot_free;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] srch_idx;
  logic [NCH-1:0] gnt_vec;
  logic [NCH-1:0] expire;

  // Round-robin search of pending channels starting just after the last granted one.
  always_comb begin
    slot_free = !evt_valid_q || evt_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    srch_idx  = '0;
    gnt_vec   = '0;
    for (int k = 1; k <= NCH; k++) begin
      srch_idx = IDW'((int'(rr_q) + k) % NCH);
      if (!gnt_found && pending_q[srch_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = srch_idx;
      end
    end
    if (slot_free && gnt_found) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  // Per-channel next state: config write beats a same-cycle tic; grant-clear beats nothing but merges with expire.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    expire    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_vec[i]) begin
        pending_d[i] = 1'b0;
      end
      if (cfg_we && (cfg_ch == IDW'(i))) begin
        if (cfg_en && (cfg_period != '0)) begin
          state_d[i]   = S_ARMED;
          cnt_d[i]     = cfg_period;
          period_d[i]  = cfg_period;
          oneshot_d[i] = cfg_oneshot;
          overrun_d[i] = 1'b0;
        end else if (cfg_en) begin
          // Zero period is rejected: channel parks idle but an undelivered expiry survives.
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end else begin
          state_d[i]   = S_IDLE;
          cnt_d[i]     = '0;
          pending_d[i] = 1'b0;
          overrun_d[i] = 1'b0;
        end
      end else if ((state_q[i] == S_ARMED) && tic_in) begin
        if (cnt_q[i] == CW'(1)) begin
          expire[i] = 1'b1;
          if (oneshot_q[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = period_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
      if (expire[i]) begin
        // A second expiry while the first is still undelivered is merged and flagged.
        if (pending_q[i] && !gnt_vec[i]) begin
          overrun_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
  end

  // Config error flag and event slot next state.
  always_comb begin
    cfg_err_d   = cfg_we && cfg_en && (cfg_period == '0);
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_d        = rr_q;
    if (slot_free) begin
      evt_valid_d = gnt_found;
      if (gnt_found) begin
        evt_id_d = gnt_idx;
        rr_d     = gnt_idx;
      end
    end
  end

  // State registers with synchronous reset; rr starts at NCH-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= S_IDLE;
        cnt_q[i]    <= '0;
        period_q[i] <= '0;
      end
      oneshot_q   <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      cfg_err_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_q        <= IDW'(NCH - 1);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      oneshot_q   <= oneshot_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      cfg_err_q   <= cfg_err_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_q        <= rr_d;
    end
  end

  // Status outputs straight from registered state.
  always_comb begin
    armed = '0;
    for (int i = 0; i < NCH; i++) begin
      armed[i] = (state_q[i] == S_ARMED);
    end
  end

  assign overrun   = overrun_q;
  assign cfg_err   = cfg_err_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;

endmodule

// File: tb/tb_tic_timer_sched.sv
// Purpose: directed bench for tic_timer_sched with an expected-event queue.
// Latency: inputs change 1ns after a rising edge; checks sample there or at the falling edge.
// Backpressure: evt_ready is driven per step to exercise hold, merge and back-to-back delivery.
module tb_tic_timer_sched;

  localparam int NCH = 4;
  localparam int CW  = 17;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic           tic_in;
  logic           cfg_we;
  logic [IDW-1:0] cfg_ch;
  logic           cfg_en;
  logic           cfg_oneshot;
  logic [CW-1:0]  cfg_period;
  logic           cfg_err;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic [NCH-1:0] armed;
  logic [NCH-1:0] overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  tic_timer_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .tic_in      (tic_in),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_en      (cfg_en),
    .cfg_oneshot (cfg_oneshot),
    .cfg_period  (cfg_period),
    .cfg_err     (cfg_err),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .armed       (armed),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic tic();
    tic_in = 1'b1;
    step();
    tic_in = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic en, input logic os, input logic [CW-1:0] per);
    cfg_we      = 1'b1;
    cfg_ch      = IDW'(ch);
    cfg_en      = en;
    cfg_oneshot = os;
    cfg_period  = per;
    step();
    cfg_we = 1'b0;
  endtask

  // Every accepted event is checked against the next expected channel id.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt_qsize", exp_q.size(), 1);
      end else begin
        chk("evt_id", evt_id, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst         = 1'b1;
    tic_in      = 1'b0;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_en      = 1'b0;
    cfg_oneshot = 1'b0;
    cfg_period  = '0;
    evt_ready   = 1'b0;

    // 1: reset state
    do_reset();
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_id", evt_id, 0);
    chk("rst_armed", armed, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // 2: ch1 periodic period 3, tic every 5 clocks
    evt_ready = 1'b1;
    cfg(1, 1'b1, 1'b0, 17'd3);
    chk("t2_armed", armed, 4'b0010);
    for (int t = 1; t <= 9; t++) begin
      tic();
      if (t % 3 == 0) exp_q.push_back(1);
      chk("t2_pre", evt_valid, 0);
      step();
      chk("t2_evt", evt_valid, (t % 3 == 0));
      if (t % 3 == 0) chk("t2_id", evt_id, 1);
      step();
      chk("t2_post", evt_valid, 0);
      step();
      step();
    end
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: four one-shots expire together, held then drained back-to-back
    do_reset();
    evt_ready = 1'b0;
    for (int c = 0; c < NCH; c++) cfg(c, 1'b1, 1'b1, 17'd2);
    chk("t3_armed", armed, 4'b1111);
    tic();
    step();
    step();
    tic();
    for (int c = 0; c < NCH; c++) exp_q.push_back(c);
    step();
    step();
    step();
    chk("t3_hold_valid", evt_valid, 1);
    chk("t3_hold_id", evt_id, 0);
    chk("t3_armed_after", armed, 4'b0000);
    evt_ready = 1'b1;
    step();
    chk("t3_b2b_v1", evt_valid, 1);
    chk("t3_b2b_id1", evt_id, 1);
    step();
    chk("t3_b2b_id2", evt_id, 2);
    step();
    chk("t3_b2b_id3", evt_id, 3);
    step();
    chk("t3_drained", evt_valid, 0);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: overrun from repeated expiry while the event is stalled
    do_reset();
    evt_ready = 1'b0;
    cfg(2, 1'b1, 1'b0, 17'd1);
    for (int t = 0; t < 3; t++) begin
      tic();
      step();
      step();
    end
    chk("t4_overrun", overrun, 4'b0100);
    chk("t4_valid", evt_valid, 1);
    chk("t4_id", evt_id, 2);
    exp_q.push_back(2);
    cfg(2, 1'b1, 1'b0, 17'd1);
    chk("t4_overrun_clr", overrun, 4'b0000);
    cfg(2, 1'b0, 1'b0, 17'd1);
    evt_ready = 1'b1;
    step();
    step();
    step();
    chk("t4_valid_after", evt_valid, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: zero-period rejection and config beating a same-cycle tic
    do_reset();
    evt_ready = 1'b1;
    cfg(0, 1'b1, 1'b0, 17'd0);
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_armed0", armed[0], 0);
    step();
    chk("t5_cfg_err_pulse", cfg_err, 0);
    cfg(1, 1'b1, 1'b0, 17'd2);
    tic();
    step();
    cfg_we      = 1'b1;
    cfg_ch      = 2'd1;
    cfg_en      = 1'b1;
    cfg_oneshot = 1'b0;
    cfg_period  = 17'd3;
    tic_in      = 1'b1;
    step();
    cfg_we = 1'b0;
    tic_in = 1'b0;
    step();
    step();
    chk("t5_no_evt", evt_valid, 0);
    chk("t5_armed1", armed, 4'b0010);
    tic();
    step();
    tic();
    step();
    chk("t5_no_evt2", evt_valid, 0);
    exp_q.push_back(1);
    tic();
    step();
    chk("t5_evt", evt_valid, 1);
    chk("t5_evt_id", evt_id, 1);
    step();
    chk("t5_evt_done", evt_valid, 0);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: reset while an event is stalled discards it and disarms everything
    do_reset();
    evt_ready = 1'b0;
    cfg(3, 1'b1, 1'b0, 17'd1);
    tic();
    step();
    chk("t6_valid", evt_valid, 1);
    chk("t6_id", evt_id, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_armed", armed, 0);
    evt_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tic();
      step();
    end
    step();
    chk("t6_no_evt", evt_valid, 0);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
